// File: rtl/act_tile_scheduler_if.sv
// ---------------------------------------------------------------------------
// act_tile_scheduler_if
// Groups the layer-config, downstream-ready, activation-return and
// memory-start signals of the activation tile scheduler into one bundle.
//
// Modports:
//   slave  : the scheduler itself (consumes cfg_*, ds_ready, act_valid;
//            drives mem_*, tile_idx, busy, done, err_timeout)
//   master : the layer controller / host side plus the memory block
//            (drives cfg_*, ds_ready, act_valid; observes the rest)
// ---------------------------------------------------------------------------
interface act_tile_scheduler_if #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned BATCH_W = 6,
  parameter int unsigned TILE_W  = 8
);
  logic               cfg_go;
  logic [ADDR_W-1:0]  cfg_base;
  logic [ADDR_W-1:0]  cfg_stride;
  logic [TILE_W-1:0]  cfg_num_tiles;
  logic [BATCH_W-1:0] cfg_batch;
  logic               ds_ready;
  logic               act_valid;
  logic               mem_start;
  logic [ADDR_W-1:0]  mem_addr_start;
  logic [BATCH_W-1:0] mem_batch;
  logic [TILE_W-1:0]  tile_idx;
  logic               busy;
  logic               done;
  logic               err_timeout;

  modport slave (
    input  cfg_go, cfg_base, cfg_stride, cfg_num_tiles, cfg_batch,
    input  ds_ready, act_valid,
    output mem_start, mem_addr_start, mem_batch, tile_idx, busy, done, err_timeout
  );

  modport master (
    output cfg_go, cfg_base, cfg_stride, cfg_num_tiles, cfg_batch,
    output ds_ready, act_valid,
    input  mem_start, mem_addr_start, mem_batch, tile_idx, busy, done, err_timeout
  );
endinterface

// File: rtl/act_tile_scheduler.sv
// ---------------------------------------------------------------------------
// act_tile_scheduler
// Sequences the activation memory read port over a multi-tile layer pass.
// A layer config (base, stride, tile count, batch) is latched on cfg_go; one
// mem_start pulse is issued per tile with its start address, returned
// activation beats are counted to detect tile completion, and each next tile
// is gated on ds_ready.
//
// Ports:
//   clk     : clock
//   resetn  : synchronous active-low reset
//   bus     : act_tile_scheduler_if.slave
//             in : cfg_go, cfg_base, cfg_stride, cfg_num_tiles, cfg_batch,
//                  ds_ready, act_valid
//             out: mem_start, mem_addr_start, mem_batch, tile_idx, busy,
//                  done, err_timeout (all registered)
//
// Optional feature macro: ACT_SCHED_TIMEOUT_EN
//   defined   : a stall counter runs in STREAM, cleared on every beat; after
//               TIMEOUT consecutive beat-less cycles err_timeout is set
//               (sticky until the next accepted cfg_go) and the pass aborts
//               to IDLE without a done pulse. TIMEOUT exists only then.
//   undefined : no stall counter, err_timeout stays 0, STREAM waits forever.
// ---------------------------------------------------------------------------
module act_tile_scheduler #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned BATCH_W = 6,
  parameter int unsigned TILE_W  = 8
`ifdef ACT_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic                clk,
  input  logic                resetn,
  act_tile_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [BATCH_W-1:0] BEAT_ZERO = {BATCH_W{1'b0}};
  localparam logic [BATCH_W-1:0] BEAT_ONE  = {{(BATCH_W-1){1'b0}}, 1'b1};
  localparam logic [TILE_W-1:0]  TILE_ZERO = {TILE_W{1'b0}};
  localparam logic [TILE_W-1:0]  TILE_ONE  = {{(TILE_W-1){1'b0}}, 1'b1};

  state_e             state_r,     state_nxt_s;
  logic [ADDR_W-1:0]  addr_r,      addr_nxt_s;
  logic [ADDR_W-1:0]  stride_r,    stride_nxt_s;
  logic [BATCH_W-1:0] batch_r,     batch_nxt_s;
  logic [BATCH_W-1:0] beat_r,      beat_nxt_s;
  logic [TILE_W-1:0]  tile_r,      tile_nxt_s;
  logic [TILE_W-1:0]  num_tiles_r, num_tiles_nxt_s;
  logic               start_r,     start_nxt_s;
  logic               busy_r,      busy_nxt_s;
  logic               done_r,      done_nxt_s;
  logic               err_r,       err_nxt_s;
  logic               tile_last_s;

`ifdef ACT_SCHED_TIMEOUT_EN
  // Counter holds 0..TIMEOUT-1; the TIMEOUT-th quiet cycle fires the abort.
  localparam int unsigned        IDLE_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0]  IDLE_ZERO = {IDLE_W{1'b0}};
  localparam logic [IDLE_W-1:0]  IDLE_ONE  = {{(IDLE_W-1){1'b0}}, 1'b1};
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  logic [IDLE_W-1:0] idle_r, idle_nxt_s;
`endif

  // Last tile of the pass: num_tiles is never 0 here (0 skips straight to DONE).
  assign tile_last_s = (tile_r == (num_tiles_r - TILE_ONE));

  // Next-state and next-output computation for the whole scheduler.
  always_comb begin
    state_nxt_s     = state_r;
    addr_nxt_s      = addr_r;
    stride_nxt_s    = stride_r;
    batch_nxt_s     = batch_r;
    beat_nxt_s      = beat_r;
    tile_nxt_s      = tile_r;
    num_tiles_nxt_s = num_tiles_r;
    err_nxt_s       = err_r;
    start_nxt_s     = 1'b0;
    done_nxt_s      = 1'b0;
`ifdef ACT_SCHED_TIMEOUT_EN
    idle_nxt_s      = idle_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.cfg_go) begin
          addr_nxt_s      = bus.cfg_base;
          stride_nxt_s    = bus.cfg_stride;
          batch_nxt_s     = bus.cfg_batch;
          num_tiles_nxt_s = bus.cfg_num_tiles;
          tile_nxt_s      = TILE_ZERO;
          beat_nxt_s      = BEAT_ZERO;
          err_nxt_s       = 1'b0;
          if (bus.cfg_num_tiles == TILE_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.ds_ready) begin
          start_nxt_s = 1'b1;
          state_nxt_s = ST_STREAM;
`ifdef ACT_SCHED_TIMEOUT_EN
          idle_nxt_s  = IDLE_ZERO;
`endif
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_STREAM: begin
        if (bus.act_valid) begin
`ifdef ACT_SCHED_TIMEOUT_EN
          idle_nxt_s = IDLE_ZERO;
`endif
          if (beat_r == batch_r) begin
            // Final beat of the tile; address/batch stay stable until here.
            beat_nxt_s = BEAT_ZERO;
            if (tile_last_s) begin
              state_nxt_s = ST_DONE;
            end else begin
              tile_nxt_s  = tile_r + TILE_ONE;
              addr_nxt_s  = addr_r + stride_r;  // wraps modulo 2^ADDR_W
              state_nxt_s = ST_ISSUE;
            end
          end else begin
            beat_nxt_s = beat_r + BEAT_ONE;
          end
        end else begin
`ifdef ACT_SCHED_TIMEOUT_EN
          if (idle_r == IDLE_LAST) begin
            err_nxt_s   = 1'b1;
            beat_nxt_s  = BEAT_ZERO;
            idle_nxt_s  = IDLE_ZERO;
            state_nxt_s = ST_IDLE;
          end else begin
            idle_nxt_s  = idle_r + IDLE_ONE;
          end
`else
          state_nxt_s = ST_STREAM;
`endif
        end
      end
      ST_DONE: begin
        done_nxt_s  = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      addr_r      <= ADDR_ZERO;
      stride_r    <= ADDR_ZERO;
      batch_r     <= BEAT_ZERO;
      beat_r      <= BEAT_ZERO;
      tile_r      <= TILE_ZERO;
      num_tiles_r <= TILE_ZERO;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef ACT_SCHED_TIMEOUT_EN
      idle_r      <= IDLE_ZERO;
`endif
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      stride_r    <= stride_nxt_s;
      batch_r     <= batch_nxt_s;
      beat_r      <= beat_nxt_s;
      tile_r      <= tile_nxt_s;
      num_tiles_r <= num_tiles_nxt_s;
      start_r     <= start_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
`ifdef ACT_SCHED_TIMEOUT_EN
      idle_r      <= idle_nxt_s;
`endif
    end
  end

  assign bus.mem_start      = start_r;
  assign bus.mem_addr_start = addr_r;
  assign bus.mem_batch      = batch_r;
  assign bus.tile_idx       = tile_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.err_timeout    = err_r;

endmodule

// File: tb/tb_act_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_act_tile_scheduler
// Directed bench for act_tile_scheduler. A pass-level reference model tracks
// what each output must be (tile addresses as base + n*stride modulo 2^11),
// and a negedge process compares every output every cycle. Hand-computed
// literals pin the model: start addresses, go-to-done latency, ready gating,
// wrap, reset mid-pass, and the stall behaviour of the ACT_SCHED_TIMEOUT_EN
// build (or its absence in the default build).
// ---------------------------------------------------------------------------
module tb_act_tile_scheduler;
  localparam int ADDR_W   = 11;
  localparam int BATCH_W  = 6;
  localparam int TILE_W   = 8;
  localparam int ADDR_MOD = 2048;
`ifdef ACT_SCHED_TIMEOUT_EN
  localparam int TIMEOUT  = 64;
`endif

  logic clk;
  logic resetn;
  act_tile_scheduler_if #(.ADDR_W(ADDR_W), .BATCH_W(BATCH_W), .TILE_W(TILE_W)) bus ();

  act_tile_scheduler #(.ADDR_W(ADDR_W), .BATCH_W(BATCH_W), .TILE_W(TILE_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // stimulus knobs for the memory responder
  bit auto_mem = 1'b1;
  bit stray_valid = 1'b0;
  int beat_cap = 1000;
  int cur_batch = 0;

  // monitor results
  int starts_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int go_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (pass level) ----------------
  int m_mode;        // 0 idle, 1 waiting for ready, 2 receiving beats, 3 finishing
  int m_tile, m_beats, m_quiet, m_addr, m_batch;
  int c_base, c_stride, c_tiles;
  bit m_start, m_done, m_busy, m_err;

  always @(posedge clk) begin
    if (!resetn) begin
      m_mode <= 0; m_tile <= 0; m_beats <= 0; m_quiet <= 0; m_addr <= 0; m_batch <= 0;
      m_start <= 1'b0; m_done <= 1'b0; m_busy <= 1'b0; m_err <= 1'b0;
    end else begin
      m_start <= 1'b0;
      m_done  <= 1'b0;
      case (m_mode)
        0: if (bus.cfg_go) begin
          c_base <= int'(bus.cfg_base); c_stride <= int'(bus.cfg_stride);
          c_tiles <= int'(bus.cfg_num_tiles);
          m_addr <= int'(bus.cfg_base); m_batch <= int'(bus.cfg_batch);
          m_tile <= 0; m_beats <= 0; m_err <= 1'b0; m_busy <= 1'b1;
          m_mode <= (bus.cfg_num_tiles == 8'd0) ? 3 : 1;
        end
        1: if (bus.ds_ready) begin
          m_start <= 1'b1; m_mode <= 2; m_quiet <= 0;
        end
        2: if (bus.act_valid) begin
          m_quiet <= 0;
          if (m_beats + 1 == m_batch + 1) begin
            m_beats <= 0;
            if (m_tile + 1 == c_tiles) m_mode <= 3;
            else begin
              m_tile <= m_tile + 1;
              m_addr <= (c_base + (m_tile + 1) * c_stride) % ADDR_MOD;
              m_mode <= 1;
            end
          end else m_beats <= m_beats + 1;
        end else begin
`ifdef ACT_SCHED_TIMEOUT_EN
          if (m_quiet + 1 == TIMEOUT) begin
            m_err <= 1'b1; m_busy <= 1'b0; m_mode <= 0; m_beats <= 0;
          end else m_quiet <= m_quiet + 1;
`endif
        end
        3: begin m_done <= 1'b1; m_busy <= 1'b0; m_mode <= 0; end
        default: m_mode <= 0;
      endcase
    end
  end

  // ---------------- compare + monitor ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_start", bus.mem_start, m_start);
      chk("mem_addr_start", bus.mem_addr_start, m_addr);
      chk("mem_batch", bus.mem_batch, m_batch);
      chk("tile_idx", bus.tile_idx, m_tile);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("err_timeout", bus.err_timeout, m_err);
    end
    if (bus.mem_start === 1'b1) begin starts_q.push_back(int'(bus.mem_addr_start)); start_cyc = cyc; end
    if (bus.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
  end

  // ---------------- memory responder ----------------
  initial begin
    int left;
    bit pend;
    left = 0; pend = 1'b0;
    bus.act_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin left = 0; pend = 1'b0; end
      if (left > 0) begin bus.act_valid = 1'b1; left--; end
      else bus.act_valid = stray_valid;
      if (pend) begin left = (cur_batch + 1 < beat_cap) ? cur_batch + 1 : beat_cap; pend = 1'b0; end
      if (auto_mem && bus.mem_start === 1'b1 && resetn) pend = 1'b1;
    end
  end

  task automatic go_pass(input int base, input int stride, input int tiles, input int batch);
    @(negedge clk);
    bus.cfg_base = ADDR_W'(base); bus.cfg_stride = ADDR_W'(stride);
    bus.cfg_num_tiles = TILE_W'(tiles); bus.cfg_batch = BATCH_W'(batch);
    cur_batch = batch;
    bus.cfg_go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    bus.cfg_go = 1'b0;
  endtask

  task automatic wait_not_busy(input int limit, input string nm);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < limit) begin @(negedge clk); k++; end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles, required 0", nm, bus.busy, limit);
    end
    @(negedge clk);
  endtask

  task automatic wait_start(input int limit, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.mem_start !== 1'b1 && k < limit) begin @(negedge clk); k++; end
    n_checks++;
    if (bus.mem_start !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_wait_start: no mem_start within %0d cycles", nm, limit);
    end
  endtask

  task automatic chk_starts(input string nm, input int a0, input int a1, input int a2, input int n);
    chk({nm, "_nstarts"}, starts_q.size(), n);
    if (starts_q.size() == n) begin
      if (n > 0) chk({nm, "_addr0"}, starts_q[0], a0);
      if (n > 1) chk({nm, "_addr1"}, starts_q[1], a1);
      if (n > 2) chk({nm, "_addr2"}, starts_q[2], a2);
    end
  endtask

  initial begin
    int d0;
    resetn = 1'b0;
    bus.cfg_go = 1'b0; bus.cfg_base = '0; bus.cfg_stride = '0;
    bus.cfg_num_tiles = '0; bus.cfg_batch = '0; bus.ds_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    // reset state, literal expectations
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_start", bus.mem_start, 1'b0);
    chk("rst_addr", bus.mem_addr_start, 11'h000);
    chk("rst_tile", bus.tile_idx, 8'd0);
    resetn = 1'b1;

    // stray beats in IDLE must be ignored
    stray_valid = 1'b1;
    repeat (3) @(negedge clk);
    stray_valid = 1'b0;

    // T1: base 0x100, stride 0x40, 3 tiles of 4 beats
    starts_q.delete(); d0 = done_cnt;
    go_pass(32'h100, 32'h40, 3, 3);
    // a go while busy must be ignored
    repeat (2) @(negedge clk);
    bus.cfg_base = 11'h555; bus.cfg_num_tiles = 8'd9; bus.cfg_go = 1'b1;
    @(negedge clk);
    bus.cfg_go = 1'b0;
    wait_not_busy(200, "t1");
    chk_starts("t1", 32'h100, 32'h140, 32'h180, 3);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_go_to_done", done_cyc - go_cyc, 23);

    // T2: empty pass, done two cycles after go, no mem_start
    starts_q.delete(); d0 = done_cnt;
    @(negedge clk);
    bus.cfg_num_tiles = 8'd0; bus.cfg_go = 1'b1;
    @(negedge clk);
    bus.cfg_go = 1'b0;
    chk("t2_busy_c1", bus.busy, 1'b1);
    chk("t2_done_c1", bus.done, 1'b0);
    @(negedge clk);
    chk("t2_done_c2", bus.done, 1'b1);
    chk("t2_busy_c2", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_nstarts", starts_q.size(), 0);
    chk("t2_done_cnt", done_cnt - d0, 1);

    // T3: ds_ready low for 10 cycles after tile 0 start
    starts_q.delete();
    go_pass(32'h040, 32'h008, 2, 1);
    wait_start(20, "t3");
    bus.ds_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3_held_starts", starts_q.size(), 1);
    chk("t3_held_busy", bus.busy, 1'b1);
    bus.ds_ready = 1'b1;
    @(negedge clk);
    chk("t3_start_after_rise", bus.mem_start, 1'b1);
    chk("t3_addr_after_rise", bus.mem_addr_start, 11'h048);
    wait_not_busy(100, "t3");

    // T4: address wrap
    starts_q.delete();
    go_pass(32'h7F0, 32'h020, 2, 0);
    wait_not_busy(100, "t4");
    chk_starts("t4", 32'h7F0, 32'h010, 0, 2);

    // T5: reset mid-STREAM, then a clean pass
    starts_q.delete(); beat_cap = 3;
    go_pass(32'h300, 32'h100, 3, 7);
    wait_start(20, "t5");
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    beat_cap = 1000; d0 = done_cnt;
    chk("t5_rst_busy", bus.busy, 1'b0);
    chk("t5_rst_tile", bus.tile_idx, 8'd0);
    repeat (4) @(negedge clk);
    chk("t5_no_stale_done", done_cnt - d0, 0);
    starts_q.delete();
    go_pass(32'h200, 32'h010, 2, 1);
    wait_not_busy(100, "t5");
    chk_starts("t5", 32'h200, 32'h210, 0, 2);
    chk("t5_done_cnt", done_cnt - d0, 1);

    // T6: tile stalls after 2 of 4 beats
    d0 = done_cnt; beat_cap = 2;
    go_pass(32'h000, 32'h000, 1, 3);
`ifdef ACT_SCHED_TIMEOUT_EN
    wait_not_busy(200, "t6");
    chk("t6_err", bus.err_timeout, 1'b1);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_abort_latency", cyc - 1 - start_cyc, 68);
    beat_cap = 1000;
    go_pass(32'h000, 32'h000, 0, 0);
    chk("t6_err_cleared", bus.err_timeout, 1'b0);
    wait_not_busy(20, "t6b");
`else
    repeat (100) @(negedge clk);
    chk("t6_still_busy", bus.busy, 1'b1);
    chk("t6_err_zero", bus.err_timeout, 1'b0);
    beat_cap = 1000;
    stray_valid = 1'b1;
    repeat (2) @(negedge clk);
    stray_valid = 1'b0;
    wait_not_busy(20, "t6");
    chk("t6_done_cnt", done_cnt - d0, 1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required finish");
    $fatal(1);
  end

endmodule
